shared_mem_access_controller: RTL and testbench
===============================================

# shared_mem_access_controller

Downstream consumer of the three-CPU round-robin arbiter's 2-bit `grant` code. It latches the granted CPU's request and runs one access on the single shared memory port with a ready handshake and timeout. It then returns a one-cycle completion or error pulse and read data to the owning CPU. Grant changes during an access are ignored; ownership is fixed from issue to response.

## Interface

Parameters:
- `AW`, 8, address width
- `DW`, 8, data width
- `TIMEOUT`, 15, max ACCESS cycles without `mem_ready` before error (≥1)

Ports:
- `clk`  in  1  clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `grant`  in  2  arbiter code: 00 none, 01 CPU1, 10 CPU2, 11 CPU3
- `req1`, `req2`, `req3`  in  1 each  CPU request lines (same as arbiter inputs)
- `addr1`, `addr2`, `addr3`  in  AW each  CPU addresses
- `wdata1`, `wdata2`, `wdata3`  in  DW each  CPU write data
- `we1`, `we2`, `we3`  in  1 each  1 = write, 0 = read
- `mem_req`  out  1  memory access strobe, held through access
- `mem_we`  out  1  latched write enable
- `mem_addr`  out  AW  latched address
- `mem_wdata`  out  DW  latched write data
- `mem_rdata`  in  DW  memory read data, valid with `mem_ready`
- `mem_ready`  in  1  memory completion
- `rdata`  out  DW  last read data, held until next successful read
- `done`  out  3  one-hot completion pulse, bit n-1 = CPUn
- `err`  out  3  one-hot timeout pulse, bit n-1 = CPUn
- `busy`  out  1  high when state ≠ IDLE
- `owner`  out  2  grant code of current/last access

## Operation

- States: IDLE, ACCESS, RESP; all outputs registered.
- IDLE: capture condition = `grant` ≠ 00 and that CPU's `req` high. On capture:
  - `owner` ← `grant`; `mem_addr`, `mem_wdata` and `mem_we` ← that CPU's inputs.
  - `mem_req` ← 1, wait counter ← 0, go ACCESS.
  - `grant` = 00, or granted CPU not requesting: stay IDLE, nothing changes.
- ACCESS: `mem_req`, `mem_addr`, `mem_wdata`, `mem_we` and `owner` held stable. `grant`, `req*` and CPU bus inputs are ignored.
  - `mem_ready` = 1: `mem_req` ← 0. If `mem_we` = 0, `rdata` ← `mem_rdata`. Set `done[owner-1]` ← 1, go RESP.
  - Else counter increments. When counter reaches TIMEOUT-1 without ready: `mem_req` ← 0, `err[owner-1]` ← 1, `rdata` unchanged, go RESP.
  - Ready in the final allowed cycle wins over timeout (done, not err).
- RESP: exactly one cycle. Clear `done`/`err`, go IDLE. No capture occurs in RESP.
- `mem_ready` is ignored outside ACCESS.
- Writes never modify `rdata`. `owner` retains its value in IDLE.
- `done` and `err` are never both set, and at most one bit is set.
- Counter width is ceil(log2(TIMEOUT+1)). No wrap is possible; the counter clears on each capture.

## Timing

- Reset (any state, including mid-ACCESS):
  - Next edge: state IDLE, all outputs 0 (`mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `rdata`, `done`, `err`, `busy`, `owner`).
  - Aborted access produces no `done`/`err`.
- Capture sampled in IDLE cycle T:
  - `mem_req` = `busy` = 1 from cycle T+1.
  - `mem_ready` sampled from T+1.
- Ready high in cycle T+k (k ≥ 1):
  - `done`/`rdata` visible in T+k+1, `mem_req` low in T+k+1.
  - Back in IDLE at T+k+2; next capture sampled at T+k+2 earliest.
  - Best case: 3 cycles per access (grant to done = 2 cycles).
- No ready: `err` pulse visible in T+TIMEOUT+1, with `mem_req` high for exactly TIMEOUT cycles.
- Back-to-back: `mem_req` is low for at least 2 cycles (RESP, IDLE) between accesses.

## Test plan

- Reset, then `grant`=01, `req1`=1, `we1`=0, `addr1`=8'h10, memory ready 1 cycle after `mem_req` with `mem_rdata`=8'hA5 -> `mem_addr`=8'h10 from T+1; `done`=3'b001 for one cycle; `rdata`=8'hA5 held; `owner`=01.
- `grant`=10, `we2`=1, `addr2`=8'h22, `wdata2`=8'h5C; `grant` toggles 11/01 during ACCESS; ready after 4 cycles -> `mem_addr`/`mem_wdata` stable; `done`=3'b010; `rdata` unchanged; `owner` stays 10.
- `grant`=11 with `req3`=0, then `grant`=00 -> stays IDLE, `mem_req`=0, `busy`=0.
- `grant`=11, `req3`=1, `mem_ready` never asserted, TIMEOUT=15 -> `mem_req` high exactly 15 cycles; `err`=3'b100 one cycle; `done`=0.
- Ready on the 15th ACCESS cycle -> `done`=3'b100, `err`=0.
- `reset` pulsed 2 cycles into ACCESS -> next cycle all outputs 0, no `done`/`err`; new grant captured normally after reset release.

Source files
------------

// File: rtl/shared_mem_access_controller.sv
// shared_mem_access_controller: runs one granted CPU access on the shared memory port with timeout.
module shared_mem_access_controller #(
  parameter int AW = 8,
  parameter int DW = 8,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    grant,
  input  logic          req1,
  input  logic          req2,
  input  logic          req3,
  input  logic [AW-1:0] addr1,
  input  logic [AW-1:0] addr2,
  input  logic [AW-1:0] addr3,
  input  logic [DW-1:0] wdata1,
  input  logic [DW-1:0] wdata2,
  input  logic [DW-1:0] wdata3,
  input  logic          we1,
  input  logic          we2,
  input  logic          we3,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic [DW-1:0] rdata,
  output logic [2:0]    done,
  output logic [2:0]    err,
  output logic          busy,
  output logic [1:0]    owner
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic mem_req_n, mem_we_n;
  logic [AW-1:0] mem_addr_n;
  logic [DW-1:0] mem_wdata_n, rdata_n;
  logic [2:0] done_n, err_n, owner_hot;
  logic [1:0] owner_n;
  logic sel_req, sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  assign sel_req   = grant == 2'd1 ? req1   : grant == 2'd2 ? req2   : grant == 2'd3 ? req3 : 1'b0;
  assign sel_we    = grant == 2'd1 ? we1    : grant == 2'd2 ? we2    : we3;
  assign sel_addr  = grant == 2'd1 ? addr1  : grant == 2'd2 ? addr2  : addr3;
  assign sel_wdata = grant == 2'd1 ? wdata1 : grant == 2'd2 ? wdata2 : wdata3;
  assign owner_hot = 3'b001 << (owner - 2'd1);
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    mem_req_n = mem_req;
    mem_we_n = mem_we;
    mem_addr_n = mem_addr;
    mem_wdata_n = mem_wdata;
    rdata_n = rdata;
    owner_n = owner;
    done_n = 3'b000;
    err_n = 3'b000;
    case (state)
      IDLE: if (sel_req) begin
        owner_n = grant;
        mem_addr_n = sel_addr;
        mem_wdata_n = sel_wdata;
        mem_we_n = sel_we;
        mem_req_n = 1'b1;
        cnt_n = '0;
        state_n = ACCESS;
      end
      ACCESS: if (mem_ready) begin
        mem_req_n = 1'b0;
        rdata_n = mem_we ? rdata : mem_rdata;
        done_n = owner_hot;
        state_n = RESP;
      end else if (cnt == CW'(TIMEOUT - 1)) begin
        mem_req_n = 1'b0;
        err_n = owner_hot;
        state_n = RESP;
      end else
        cnt_n = cnt + 1'b1;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      rdata <= '0;
      owner <= 2'd0;
      done <= 3'b000;
      err <= 3'b000;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      mem_req <= mem_req_n;
      mem_we <= mem_we_n;
      mem_addr <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      rdata <= rdata_n;
      owner <= owner_n;
      done <= done_n;
      err <= err_n;
    end
endmodule

// File: tb/tb_shared_mem_access_controller.sv
// tb_shared_mem_access_controller: directed checks of capture, handshake, timeout and reset abort.
module tb_shared_mem_access_controller;
  logic clk = 0, reset = 1;
  logic [1:0] grant = 0;
  logic req1 = 0, req2 = 0, req3 = 0, we1 = 0, we2 = 0, we3 = 0;
  logic [7:0] addr1 = 0, addr2 = 0, addr3 = 0, wdata1 = 0, wdata2 = 0, wdata3 = 0;
  logic [7:0] mem_rdata = 0, mem_addr, mem_wdata, rdata;
  logic mem_ready = 0, mem_req, mem_we, busy;
  logic [2:0] done, err;
  logic [1:0] owner;
  int vectors = 0, miscompares = 0;
  shared_mem_access_controller #(.AW(8), .DW(8), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .grant(grant),
    .req1(req1), .req2(req2), .req3(req3),
    .addr1(addr1), .addr2(addr2), .addr3(addr3),
    .wdata1(wdata1), .wdata2(wdata2), .wdata3(wdata3),
    .we1(we1), .we2(we2), .we3(we3),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .rdata(rdata),
    .done(done), .err(err), .busy(busy), .owner(owner)
  );
  always #5 clk = ~clk;
  task tick;
    @(posedge clk);
    #1;
  endtask
  task test_reset;
    reset = 1;
    tick;
    vectors++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, rdata, done, err, busy, owner} !== 35'd0) begin
      miscompares++;
      $display("FAIL reset_outputs got %h want 0", {mem_req, mem_we, mem_addr, mem_wdata, rdata, done, err, busy, owner});
    end
    reset = 0;
  endtask
  task test_read;
    grant = 2'b01; req1 = 1; we1 = 0; addr1 = 8'h10;
    tick;
    vectors++;
    if ({mem_req, busy, mem_we, mem_addr, owner} !== {1'b1, 1'b1, 1'b0, 8'h10, 2'b01}) begin
      miscompares++;
      $display("FAIL read_issue got req=%b busy=%b we=%b addr=%h owner=%b want 1 1 0 10 01", mem_req, busy, mem_we, mem_addr, owner);
    end
    grant = 0; req1 = 0; mem_ready = 1; mem_rdata = 8'hA5;
    tick;
    mem_ready = 0;
    vectors++;
    if ({done, err, rdata, mem_req, busy} !== {3'b001, 3'b000, 8'hA5, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL read_done got done=%b err=%b rdata=%h req=%b busy=%b want 001 000 a5 0 1", done, err, rdata, mem_req, busy);
    end
    tick;
    vectors++;
    if ({done, busy, rdata, owner} !== {3'b000, 1'b0, 8'hA5, 2'b01}) begin
      miscompares++;
      $display("FAIL read_idle got done=%b busy=%b rdata=%h owner=%b want 000 0 a5 01", done, busy, rdata, owner);
    end
  endtask
  task test_write_grant_toggle;
    grant = 2'b10; req2 = 1; we2 = 1; addr2 = 8'h22; wdata2 = 8'h5C;
    tick;
    req1 = 1; req3 = 1; addr1 = 8'hEE; addr3 = 8'hFF; wdata3 = 8'h11;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if ({mem_req, mem_we, mem_addr, mem_wdata, owner, done, err} !== {1'b1, 1'b1, 8'h22, 8'h5C, 2'b10, 6'd0}) begin
        miscompares++;
        $display("FAIL write_hold[%0d] got req=%b we=%b addr=%h wdata=%h owner=%b done=%b err=%b", i, mem_req, mem_we, mem_addr, mem_wdata, owner, done, err);
      end
      grant = i[0] ? 2'b01 : 2'b11;
      if (i == 3) begin
        mem_ready = 1; mem_rdata = 8'h3F;
      end
      tick;
    end
    mem_ready = 0; grant = 0; req1 = 0; req2 = 0; req3 = 0;
    vectors++;
    if ({done, err, rdata, owner, mem_req} !== {3'b010, 3'b000, 8'hA5, 2'b10, 1'b0}) begin
      miscompares++;
      $display("FAIL write_done got done=%b err=%b rdata=%h owner=%b req=%b want 010 000 a5 10 0", done, err, rdata, owner, mem_req);
    end
    tick;
    vectors++;
    if ({done, busy} !== 4'b0000) begin
      miscompares++;
      $display("FAIL write_idle got done=%b busy=%b want 000 0", done, busy);
    end
  endtask
  task test_no_capture;
    grant = 2'b11; req3 = 0; req1 = 1;
    tick;
    vectors++;
    if ({mem_req, busy, owner} !== {1'b0, 1'b0, 2'b10}) begin
      miscompares++;
      $display("FAIL no_req got req=%b busy=%b owner=%b want 0 0 10", mem_req, busy, owner);
    end
    grant = 2'b00; req2 = 1; req3 = 1;
    tick;
    vectors++;
    if ({mem_req, busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL no_grant got req=%b busy=%b want 0 0", mem_req, busy);
    end
    req1 = 0; req2 = 0; req3 = 0;
  endtask
  task test_timeout;
    grant = 2'b11; req3 = 1; we3 = 0; addr3 = 8'h33;
    tick;
    grant = 0; req3 = 0;
    for (int i = 0; i < 15; i++) begin
      vectors++;
      if ({mem_req, done, err, mem_addr} !== {1'b1, 6'd0, 8'h33}) begin
        miscompares++;
        $display("FAIL timeout_wait[%0d] got req=%b done=%b err=%b addr=%h want 1 000 000 33", i, mem_req, done, err, mem_addr);
      end
      tick;
    end
    vectors++;
    if ({mem_req, done, err, rdata, owner} !== {1'b0, 3'b000, 3'b100, 8'hA5, 2'b11}) begin
      miscompares++;
      $display("FAIL timeout_err got req=%b done=%b err=%b rdata=%h owner=%b want 0 000 100 a5 11", mem_req, done, err, rdata, owner);
    end
    tick;
    vectors++;
    if ({err, busy} !== 4'b0000) begin
      miscompares++;
      $display("FAIL timeout_idle got err=%b busy=%b want 000 0", err, busy);
    end
  endtask
  task test_ready_last_cycle;
    grant = 2'b11; req3 = 1; we3 = 0; addr3 = 8'h34;
    tick;
    grant = 0; req3 = 0;
    for (int i = 0; i < 14; i++) tick;
    vectors++;
    if ({mem_req, err} !== {1'b1, 3'b000}) begin
      miscompares++;
      $display("FAIL last_wait got req=%b err=%b want 1 000", mem_req, err);
    end
    mem_ready = 1; mem_rdata = 8'h3C;
    tick;
    mem_ready = 0;
    vectors++;
    if ({done, err, rdata, mem_req} !== {3'b100, 3'b000, 8'h3C, 1'b0}) begin
      miscompares++;
      $display("FAIL last_ready got done=%b err=%b rdata=%h req=%b want 100 000 3c 0", done, err, rdata, mem_req);
    end
    tick;
  endtask
  task test_reset_mid_access;
    grant = 2'b01; req1 = 1; we1 = 1; addr1 = 8'h44; wdata1 = 8'h77;
    tick;
    tick;
    vectors++;
    if ({mem_req, mem_addr, mem_wdata} !== {1'b1, 8'h44, 8'h77}) begin
      miscompares++;
      $display("FAIL mid_access got req=%b addr=%h wdata=%h want 1 44 77", mem_req, mem_addr, mem_wdata);
    end
    reset = 1;
    tick;
    grant = 0; req1 = 0;
    vectors++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, rdata, done, err, busy, owner} !== 35'd0) begin
      miscompares++;
      $display("FAIL mid_reset got %h want 0", {mem_req, mem_we, mem_addr, mem_wdata, rdata, done, err, busy, owner});
    end
    reset = 0;
    tick;
    vectors++;
    if ({done, err, busy, mem_req} !== 8'd0) begin
      miscompares++;
      $display("FAIL post_reset got done=%b err=%b busy=%b req=%b want 000 000 0 0", done, err, busy, mem_req);
    end
    grant = 2'b01; req1 = 1; we1 = 0; addr1 = 8'h55;
    tick;
    grant = 0; req1 = 0;
    vectors++;
    if ({mem_req, mem_addr, mem_we, owner} !== {1'b1, 8'h55, 1'b0, 2'b01}) begin
      miscompares++;
      $display("FAIL recapture got req=%b addr=%h we=%b owner=%b want 1 55 0 01", mem_req, mem_addr, mem_we, owner);
    end
    mem_ready = 1; mem_rdata = 8'h99;
    tick;
    mem_ready = 0;
    vectors++;
    if ({done, rdata} !== {3'b001, 8'h99}) begin
      miscompares++;
      $display("FAIL recapture_done got done=%b rdata=%h want 001 99", done, rdata);
    end
    tick;
  endtask
  initial begin
    test_reset;
    test_read;
    test_write_grant_toggle;
    test_no_capture;
    test_timeout;
    test_ready_last_cycle;
    test_reset_mid_access;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
